// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: 12-state FSM that sequences the shared-memory
// 32-bit datapath (lw/sw/R-type/addi/andi/ori/beq/j) with a memory ready handshake.
module mips_multicycle_control (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       ext_op,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    state_t cur_state, nxt_state;
    logic   op_legal;

    assign state = cur_state;

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
            OP_ADDI, OP_ANDI, OP_ORI: op_legal = 1'b1;
            default:                  op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur_state <= S_FETCH;
        else          cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH:     nxt_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:               nxt_state = S_R_EXEC;
                    OP_LW, OP_SW:           nxt_state = S_MEM_ADDR;
                    OP_BEQ:                 nxt_state = S_BRANCH;
                    OP_J:                   nxt_state = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI: nxt_state = S_I_EXEC;
                    default:                nxt_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      nxt_state = S_MEM_READ;
                else if (opcode == OP_SW) nxt_state = S_MEM_WRITE;
                else                      nxt_state = S_FETCH;
            end
            S_MEM_READ:  nxt_state = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: nxt_state = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    nxt_state = S_R_WB;
            S_I_EXEC:    nxt_state = S_I_WB;
            default:     nxt_state = S_FETCH;
        endcase
    end

    // Outputs are gated by reset_n directly so strobes drop asynchronously.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        ext_op        = 1'b0;
        illegal_op    = 1'b0;
        if (reset_n) begin
            ext_op = 1'b1;
            case (cur_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = !op_legal;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b11;
                    ext_op    = (opcode == OP_ADDI);
                end
                S_I_WB: begin
                    reg_write = 1'b1;
                end
                default: ext_op = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed cycle-by-cycle bench for the multicycle MIPS control FSM.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_op, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    mips_multicycle_control dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .ext_op(ext_op), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    // {pc_write,pc_write_cond,iord,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,
    //  reg_write,alu_src_a,alu_src_b,alu_op,pc_source,ext_op,illegal_op}
    logic [17:0] outs;
    assign outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, ext_op, illegal_op};

    localparam logic [17:0] O_ZERO  = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] O_F0    = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_1_0;
    localparam logic [17:0] O_F1    = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_1_0;
    localparam logic [17:0] O_DEC   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
    localparam logic [17:0] O_DECX  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_1;
    localparam logic [17:0] O_MADDR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_1_0;
    localparam logic [17:0] O_MRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_1_0;
    localparam logic [17:0] O_MWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
    localparam logic [17:0] O_MWR   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [17:0] O_REX   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_1_0;
    localparam logic [17:0] O_RWB   = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
    localparam logic [17:0] O_BR    = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [17:0] O_J     = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
    localparam logic [17:0] O_IEXS  = 18'b0_0_0_0_0_0_0_0_0_1_10_11_00_1_0;
    localparam logic [17:0] O_IEXZ  = 18'b0_0_0_0_0_0_0_0_0_1_10_11_00_0_0;
    localparam logic [17:0] O_IWB   = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, BAD = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] out;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [3:0] exp_st, input logic [17:0] exp_out);
        checks++;
        if (state !== exp_st) begin
            failures++;
            $display("FAIL %s state actual=%0d required=%0d", nm, state, exp_st);
        end
        checks++;
        if (outs !== exp_out) begin
            failures++;
            $display("FAIL %s outputs actual=%b required=%b", nm, outs, exp_out);
        end
    endtask

    // Drive inputs just after a falling edge, check, then wait for the next falling edge.
    task automatic step(input string nm, input logic [5:0] op, input logic mr,
                        input logic [3:0] exp_st, input logic [17:0] exp_out);
        opcode    = op;
        mem_ready = mr;
        #1;
        chk(nm, exp_st, exp_out);
        @(negedge clk);
    endtask

    initial begin
        // lw: 2 FETCH waits, 1 MEM_READ wait; mem_ready toggled in ignoring states
        vecs.push_back('{LW, 1'b0, 4'd0, O_F0});
        vecs.push_back('{LW, 1'b0, 4'd0, O_F0});
        vecs.push_back('{LW, 1'b1, 4'd0, O_F1});
        vecs.push_back('{LW, 1'b0, 4'd1, O_DEC});
        vecs.push_back('{LW, 1'b0, 4'd2, O_MADDR});
        vecs.push_back('{LW, 1'b0, 4'd3, O_MRD});
        vecs.push_back('{LW, 1'b1, 4'd3, O_MRD});
        vecs.push_back('{LW, 1'b0, 4'd4, O_MWB});
        // R-type
        vecs.push_back('{RT, 1'b1, 4'd0, O_F1});
        vecs.push_back('{RT, 1'b1, 4'd1, O_DEC});
        vecs.push_back('{RT, 1'b0, 4'd6, O_REX});
        vecs.push_back('{RT, 1'b1, 4'd7, O_RWB});
        // addi then ori then andi
        vecs.push_back('{ADDI, 1'b1, 4'd0, O_F1});
        vecs.push_back('{ADDI, 1'b1, 4'd1, O_DEC});
        vecs.push_back('{ADDI, 1'b1, 4'd10, O_IEXS});
        vecs.push_back('{ADDI, 1'b1, 4'd11, O_IWB});
        vecs.push_back('{ORI, 1'b1, 4'd0, O_F1});
        vecs.push_back('{ORI, 1'b1, 4'd1, O_DEC});
        vecs.push_back('{ORI, 1'b1, 4'd10, O_IEXZ});
        vecs.push_back('{ORI, 1'b1, 4'd11, O_IWB});
        vecs.push_back('{ANDI, 1'b1, 4'd0, O_F1});
        vecs.push_back('{ANDI, 1'b1, 4'd1, O_DEC});
        vecs.push_back('{ANDI, 1'b0, 4'd10, O_IEXZ});
        vecs.push_back('{ANDI, 1'b0, 4'd11, O_IWB});
        // beq then j
        vecs.push_back('{BEQ, 1'b1, 4'd0, O_F1});
        vecs.push_back('{BEQ, 1'b1, 4'd1, O_DEC});
        vecs.push_back('{BEQ, 1'b1, 4'd8, O_BR});
        vecs.push_back('{JMP, 1'b1, 4'd0, O_F1});
        vecs.push_back('{JMP, 1'b1, 4'd1, O_DEC});
        vecs.push_back('{JMP, 1'b0, 4'd9, O_J});
        // illegal opcode: one-cycle pulse, back to FETCH
        vecs.push_back('{BAD, 1'b1, 4'd0, O_F1});
        vecs.push_back('{BAD, 1'b1, 4'd1, O_DECX});
        vecs.push_back('{BAD, 1'b0, 4'd0, O_F0});
        vecs.push_back('{BAD, 1'b1, 4'd0, O_F1});
        // sw with no wait
        vecs.push_back('{SW, 1'b1, 4'd1, O_DEC});
        vecs.push_back('{SW, 1'b1, 4'd2, O_MADDR});
        vecs.push_back('{SW, 1'b1, 4'd5, O_MWR});
        vecs.push_back('{SW, 1'b0, 4'd0, O_F0});

        reset_n   = 1'b0;
        opcode    = LW;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_hold", 4'd0, O_ZERO);

        // release mid-cycle: FETCH outputs must appear without a clock edge
        mem_ready = 1'b0;
        reset_n   = 1'b1;
        #1;
        chk("reset_release", 4'd0, O_F0);
        @(negedge clk);

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].op, vecs[i].mr, vecs[i].st, vecs[i].out);
        end

        // sw abandoned by reset during the MEM_WRITE wait
        step("sw_f",    SW, 1'b1, 4'd0, O_F1);
        step("sw_d",    SW, 1'b1, 4'd1, O_DEC);
        step("sw_addr", SW, 1'b1, 4'd2, O_MADDR);
        opcode    = SW;
        mem_ready = 1'b0;
        #1;
        chk("sw_wait", 4'd5, O_MWR);
        #2;
        reset_n = 1'b0;
        #1;
        chk("sw_async_reset", 4'd0, O_ZERO);
        @(negedge clk);
        #1;
        chk("sw_reset_held", 4'd0, O_ZERO);
        reset_n = 1'b1;
        #1;
        chk("post_reset_fetch", 4'd0, O_F0);
        @(negedge clk);
        step("post_reset_f1",  RT, 1'b1, 4'd0, O_F1);
        step("post_reset_dec", RT, 1'b1, 4'd1, O_DEC);
        step("post_reset_rex", RT, 1'b1, 4'd6, O_REX);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for the 32-bit MIPS datapath.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  6  instruction[31:26] from the instruction register, stable from DECODE until return to FETCH.
REQ-005 mem_ready  input  1  memory handshake; access completes in the cycle it is 1.
REQ-006 pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath strobes and selects.
REQ-007 alu_src_b  output  2  selects: 00=regB, 01=const 4, 10=extended imm, 11=extended imm<<2.
REQ-008 alu_op  output  2  selects: 00=add, 01=sub, 10=funct decode, 11=opcode decode.
REQ-009 pc_source  output  2  selects: 00=ALU result, 01=ALUOut, 10=jump target.
REQ-010 ext_op  output  1  immediate extender mode; 1=sign extend, 0=zero extend.
REQ-011 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-012 state  output  4  current state encoding, for debug.

Function
REQ-013 The block SHALL be a 12-state FSM: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11.
REQ-014 Any output not listed for a state SHALL be 0 in that state; ext_op SHALL default to 1.
REQ-015 FETCH SHALL assert mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
REQ-016 In FETCH, ir_write and pc_write SHALL equal mem_ready combinationally; the FSM SHALL hold FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-017 DECODE SHALL assert alu_src_a=0, alu_src_b=11, alu_op=00, and then dispatch on opcode.
REQ-018 DECODE dispatch: 000000 -> R_EXEC; 100011 or 101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP; 001000, 001100 or 001101 -> I_EXEC.
REQ-019 Any other opcode in DECODE SHALL pulse illegal_op for that cycle and return to FETCH, with no write strobes asserted.
REQ-020 MEM_ADDR SHALL assert alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM_READ (opcode 100011) or MEM_WRITE (opcode 101011).
REQ-021 MEM_READ SHALL assert mem_read=1 and iord=1, hold while mem_ready=0, and go to MEM_WB on mem_ready=1.
REQ-022 MEM_WRITE SHALL assert mem_write=1 and iord=1, hold while mem_ready=0, and go to FETCH on mem_ready=1.
REQ-023 MEM_WB SHALL assert reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-024 R_EXEC SHALL assert alu_src_a=1, alu_src_b=00, alu_op=10, then go to R_WB.
REQ-025 R_WB SHALL assert reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-026 BRANCH SHALL assert alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-027 JUMP SHALL assert pc_write=1 and pc_source=10, then go to FETCH.
REQ-028 I_EXEC SHALL assert alu_src_a=1, alu_src_b=10, alu_op=11, with ext_op=1 for 001000 and ext_op=0 for 001100/001101, then go to I_WB.
REQ-029 I_WB SHALL assert reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-030 Cycle counts with mem_ready=1: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq 3, j 3; each wait cycle adds one.
REQ-031 mem_ready SHALL be ignored in every state except FETCH, MEM_READ and MEM_WRITE.
REQ-032 Unused state codes 12-15 SHALL transition to FETCH on the next edge with all outputs 0.

Reset
REQ-033 reset_n=0 SHALL force state=FETCH immediately, regardless of clk.
REQ-034 While reset_n=0, every output SHALL be 0, including mem_read, ext_op and illegal_op.
REQ-035 Reset asserted mid-operation (for example during a MEM_WRITE wait) SHALL drop mem_write in the same cycle and abandon the instruction.
REQ-036 The first FETCH outputs SHALL appear after reset_n rises, with no clock edge required.

Verification
REQ-037 lw (100011) with mem_ready low for 2 cycles in FETCH and 1 cycle in MEM_READ -> state sequence 0,0,0,1,2,3,3,4,0, and reg_write=1 only in state 4.
REQ-038 R-type (000000) with mem_ready=1 -> 0,1,6,7,0; alu_op=10 in state 6; reg_dst=1 and reg_write=1 in state 7.
REQ-039 addi (001000) then ori (001101) -> ext_op=1 in I_EXEC for addi, ext_op=0 in I_EXEC for ori; alu_src_b=10 in both.
REQ-040 beq (000100) then j (000010) -> pc_write_cond=1 with pc_source=01 in state 8; pc_write=1 with pc_source=10 in state 9.
REQ-041 opcode 111111 -> illegal_op=1 for exactly one cycle in DECODE, next state 0, no reg_write, mem_write or pc_write.
REQ-042 sw with reset_n pulled low during the MEM_WRITE wait -> mem_write=0 and state=0 asynchronously; after release, a normal FETCH follows.
